// File: rtl/envia_medida_serial.sv
// Sends a captured 3-digit BCD distance as ASCII "<h><t><u>#" over 7O2 async serial.
// Define ENVIA_MEDIDA_CR_EN to append a CR (0x0D) character after '#'.
module envia_medida_serial #(
  parameter int DIV = 434
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [11:0] medida,
  input  logic        pronto,
  output logic        saida_serial,
  output logic        ocupado,
  output logic        fim_envio,
  output logic [3:0]  db_estado
);

  localparam int BW = $clog2(DIV);
  localparam logic [BW-1:0] BAUD_MAX = BW'(DIV - 1);
  localparam logic [3:0] ULTIMO_BIT = 4'd10;
`ifdef ENVIA_MEDIDA_CR_EN
  localparam logic [2:0] ULTIMO_CHAR = 3'd4;
`else
  localparam logic [2:0] ULTIMO_CHAR = 3'd3;
`endif

  typedef enum logic [3:0] {
    INICIAL   = 4'h0,
    ESPERA    = 4'h1,
    TRANSMITE = 4'h2,
    FINAL     = 4'hF
  } t_estado;

  t_estado       r_estado, w_estado_next;
  logic [11:0]   r_medida, w_medida_next;
  logic [2:0]    r_char, w_char_next;
  logic [3:0]    r_bit, w_bit_next;
  logic [BW-1:0] r_baud, w_baud_next;
  logic          r_saida, w_saida_next;

  logic [6:0]    w_dado;
  logic [10:0]   w_quadro;
  logic [3:0]    w_bit_inc;

  // Character being sent, framed LSB-first as {stop, stop, parity, data, start}
  always_comb begin
    w_dado = 7'h23;
    case (r_char)
      3'd0:    w_dado = {3'b011, r_medida[11:8]};
      3'd1:    w_dado = {3'b011, r_medida[7:4]};
      3'd2:    w_dado = {3'b011, r_medida[3:0]};
`ifdef ENVIA_MEDIDA_CR_EN
      3'd4:    w_dado = 7'h0D;
`endif
      default: w_dado = 7'h23;
    endcase
    w_quadro  = {2'b11, ~^w_dado, w_dado, 1'b0};
    w_bit_inc = r_bit + 4'd1;
  end

  always_comb begin
    w_estado_next = r_estado;
    w_medida_next = r_medida;
    w_char_next   = r_char;
    w_bit_next    = r_bit;
    w_baud_next   = r_baud;
    w_saida_next  = r_saida;
    case (r_estado)
      INICIAL: begin
        w_estado_next = ESPERA;
        w_saida_next  = 1'b1;
      end
      ESPERA: begin
        w_saida_next = 1'b1;
        if (pronto) begin
          w_medida_next = medida;
          w_char_next   = 3'd0;
          w_bit_next    = 4'd0;
          w_baud_next   = '0;
          w_saida_next  = 1'b0;
          w_estado_next = TRANSMITE;
        end
      end
      TRANSMITE: begin
        if (r_baud == BAUD_MAX) begin
          w_baud_next = '0;
          if (r_bit == ULTIMO_BIT) begin
            // Next character's start bit follows the second stop bit directly
            if (r_char == ULTIMO_CHAR) begin
              w_estado_next = FINAL;
              w_saida_next  = 1'b1;
            end else begin
              w_char_next  = r_char + 3'd1;
              w_bit_next   = 4'd0;
              w_saida_next = 1'b0;
            end
          end else begin
            w_bit_next   = w_bit_inc;
            w_saida_next = w_quadro[w_bit_inc];
          end
        end else begin
          w_baud_next = r_baud + BW'(1);
        end
      end
      FINAL: begin
        w_estado_next = ESPERA;
        w_saida_next  = 1'b1;
      end
      default: begin
        w_estado_next = INICIAL;
        w_saida_next  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_estado <= INICIAL;
      r_medida <= '0;
      r_char   <= '0;
      r_bit    <= '0;
      r_baud   <= '0;
      r_saida  <= 1'b1;
    end else begin
      r_estado <= w_estado_next;
      r_medida <= w_medida_next;
      r_char   <= w_char_next;
      r_bit    <= w_bit_next;
      r_baud   <= w_baud_next;
      r_saida  <= w_saida_next;
    end
  end

  assign saida_serial = r_saida;
  assign ocupado      = (r_estado == TRANSMITE);
  assign fim_envio    = (r_estado == FINAL);
  assign db_estado    = r_estado;

endmodule

// File: tb/tb_envia_medida_serial.sv
// Scoreboard bench for envia_medida_serial: stimulus queues expected characters
// and end-of-frame cycles; monitors decode the serial line and compare.
module tb_envia_medida_serial;

  localparam int DIV = 4;
`ifdef ENVIA_MEDIDA_CR_EN
  localparam int FL = 55 * DIV;
`else
  localparam int FL = 44 * DIV;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [11:0] medida = 12'h000;
  logic        pronto = 1'b0;
  logic        saida_serial;
  logic        ocupado;
  logic        fim_envio;
  logic [3:0]  db_estado;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [7:0] exp_q[$];   // {parity, data[6:0]}
  int         fim_q[$];   // expected cycle of fim_envio

  envia_medida_serial #(.DIV(DIV)) dut (
    .clock       (clk),
    .reset       (reset),
    .medida      (medida),
    .pronto      (pronto),
    .saida_serial(saida_serial),
    .ocupado     (ocupado),
    .fim_envio   (fim_envio),
    .db_estado   (db_estado)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end else begin
      $display("ok   %s: %0h (cycle %0d)", name, act, cyc);
    end
  endtask

  // Serial receiver: samples each bit one cycle into its DIV-cycle window
  logic        rx_active = 1'b0;
  int          rx_cnt = 0;
  logic [10:0] rx_bits = '0;
  int          occ_run = 0;
  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        rx_active = 1'b0;
        occ_run   = 0;
      end else begin
        if (!rx_active) begin
          if (saida_serial == 1'b0) begin
            rx_active = 1'b1;
            rx_cnt    = 0;
          end
        end else begin
          rx_cnt++;
          if (rx_cnt % DIV == 1) rx_bits[rx_cnt / DIV] = saida_serial;
          if (rx_cnt == 11 * DIV - 1) begin
            rx_active = 1'b0;
            if (exp_q.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL unexpected_char: got %0h expected none", rx_bits[8:1]);
            end else begin
              chk("char", {24'd0, rx_bits[8:1]}, {24'd0, exp_q.pop_front()});
            end
            chk("framing", {29'd0, rx_bits[10:9], rx_bits[0]}, 32'd6);
          end
        end
        if (fim_envio === 1'b1) begin
          if (fim_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_fim: got cycle %0d expected none", cyc);
          end else begin
            chk("fim_cycle", cyc, fim_q.pop_front());
          end
        end
        if (ocupado === 1'b1) begin
          occ_run++;
        end else if (occ_run > 0) begin
          chk("ocupado_len", occ_run, FL);
          occ_run = 0;
        end
      end
    end
  end

  task automatic push_frame(input logic [7:0] c0, input logic [7:0] c1, input logic [7:0] c2);
    exp_q.push_back(c0);
    exp_q.push_back(c1);
    exp_q.push_back(c2);
    exp_q.push_back(8'h23);
`ifdef ENVIA_MEDIDA_CR_EN
    exp_q.push_back(8'h0D);
`endif
  endtask

  // Pulses pronto for one cycle; k is the cycle count right after the accepting edge
  task automatic send(input logic [11:0] m, output int k);
    @(negedge clk);
    medida = m;
    pronto = 1'b1;
    @(negedge clk);
    pronto = 1'b0;
    k = cyc;
  endtask

  task automatic wait_fim(input string tag);
    int n = 0;
    while (fim_envio !== 1'b1 && n < FL + 20) begin
      @(negedge clk);
      n++;
    end
    if (fim_envio !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got no fim_envio expected one within %0d cycles", tag, FL + 20);
    end
  endtask

  initial begin
    int k;
    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_saida", {31'd0, saida_serial}, 1);
    chk("rst_ocupado", {31'd0, ocupado}, 0);
    chk("rst_fim", {31'd0, fim_envio}, 0);
    chk("rst_estado", {28'd0, db_estado}, 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    chk("espera_estado", {28'd0, db_estado}, 1);

    // Basic frame 123: 0x31 p0, 0x32 p0, 0x33 p1, '#' p0
    send(12'h123, k);
    push_frame(8'h31, 8'h32, 8'hB3);
    fim_q.push_back(k + FL);
    chk("accept_start", {30'd0, ocupado, saida_serial}, 2);
    wait_fim("basic");
    repeat (3) @(negedge clk);

    // Zero distance: three 0x30 with parity 1
    send(12'h000, k);
    push_frame(8'hB0, 8'hB0, 8'hB0);
    fim_q.push_back(k + FL);
    wait_fim("zero");
    repeat (3) @(negedge clk);

    // Busy drop: pronto and new medida mid-frame must be ignored
    send(12'h321, k);
    push_frame(8'hB3, 8'h32, 8'h31);
    fim_q.push_back(k + FL);
    while (cyc < k + 50) @(negedge clk);
    medida = 12'h999;
    pronto = 1'b1;
    @(negedge clk);
    pronto = 1'b0;
    wait_fim("busy");
    repeat (FL + 20) @(negedge clk);
    chk("busy_idle_estado", {28'd0, db_estado}, 1);
    chk("busy_idle_ocupado", {31'd0, ocupado}, 0);

    // Non-BCD with pronto held: second frame starts after one ESPERA cycle
    @(negedge clk);
    medida = 12'hA5F;
    pronto = 1'b1;
    @(negedge clk);
    k = cyc;
    push_frame(8'hBA, 8'hB5, 8'hBF);
    push_frame(8'hBA, 8'hB5, 8'hBF);
    fim_q.push_back(k + FL);
    fim_q.push_back(k + 2 * FL + 2);
    while (cyc < k + FL) @(negedge clk);
    chk("b2b_fim", {31'd0, fim_envio}, 1);
    @(negedge clk);
    chk("b2b_gap_line_estado", {27'd0, saida_serial, db_estado}, 32'h11);
    @(negedge clk);
    chk("b2b_restart", {26'd0, ocupado, saida_serial, db_estado}, 32'h22);
    pronto = 1'b0;
    wait_fim("b2b");
    repeat (3) @(negedge clk);

    // Reset during the second character's data bits
    send(12'h456, k);
    push_frame(8'h34, 8'hB5, 8'hB6);
    fim_q.push_back(k + FL);
    while (cyc < k + 11 * DIV + 11) @(negedge clk);
    #1 reset = 1'b1;
    #1;
    chk("midrst_saida", {31'd0, saida_serial}, 1);
    chk("midrst_ocupado", {31'd0, ocupado}, 0);
    chk("midrst_estado", {28'd0, db_estado}, 0);
    exp_q.delete();
    fim_q.delete();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    send(12'h789, k);
    push_frame(8'h37, 8'h38, 8'hB9);
    fim_q.push_back(k + FL);
    wait_fim("after_rst");
    repeat (3) @(negedge clk);

    // 042 frame (CR appended when the option is built in)
    send(12'h042, k);
    push_frame(8'hB0, 8'h34, 8'h32);
    fim_q.push_back(k + FL);
    wait_fim("cr");
    repeat (20) @(negedge clk);

    chk("chars_left", exp_q.size(), 0);
    chk("fims_left", fim_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
